// File: rtl/seqdet_param_if.sv
// ---------------------------------------------------------------------------
// seqdet_param_if -- signal bundle for the parameterised serial sequence
// detector.
//
// Parameters
//   PAT_LEN   pattern length in bits
//   CNT_W     match counter width (counter signals exist only with
//             SEQDET_CNT_EN defined)
//
// Signals
//   din_vld   serial bit qualifier
//   din       serial data bit
//   cfg_load  one-cycle pulse: load cfg_pat / cfg_ovl
//   cfg_pat   new pattern, MSB is the first bit received
//   cfg_ovl   new mode, 1 = overlapping, 0 = non-overlapping
//   result    registered one-cycle match pulse
//   cnt_clr   synchronous clear of match_cnt        (SEQDET_CNT_EN)
//   match_cnt saturating match count                (SEQDET_CNT_EN)
//
// Modports: master drives stimulus and config, slave is the detector.
// ---------------------------------------------------------------------------
interface seqdet_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               din_vld;
    logic               din;
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pat;
    logic               cfg_ovl;
    logic               result;
`ifdef SEQDET_CNT_EN
    logic               cnt_clr;
    logic [CNT_W-1:0]   match_cnt;
`endif

    modport master (
        output din_vld, din, cfg_load, cfg_pat, cfg_ovl,
`ifdef SEQDET_CNT_EN
        output cnt_clr,
        input  match_cnt,
`endif
        input  result
    );

    modport slave (
        input  din_vld, din, cfg_load, cfg_pat, cfg_ovl,
`ifdef SEQDET_CNT_EN
        input  cnt_clr,
        output match_cnt,
`endif
        output result
    );
endinterface

// File: rtl/seqdet_param.sv
// ---------------------------------------------------------------------------
// seqdet_param -- runtime-configurable serial pattern detector.
//
// Shifts qualified serial bits into a PAT_LEN-bit history and raises a
// one-cycle registered pulse on `result` in the cycle after the bit that
// completes the pattern. Overlapping or non-overlapping detection is chosen
// at runtime through cfg_load/cfg_ovl.
//
// Optional feature: define SEQDET_CNT_EN to add a saturating match counter
// (cnt_clr input, match_cnt output). Without it the counter signals and
// logic are absent and result behaviour is unchanged.
//
// Parameters
//   PAT_LEN  pattern length, 2..16
//   DEF_PAT  pattern after reset (MSB received first)
//   CNT_W    match counter width, 1..16
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   bus      seqdet_param_if.slave (din_vld, din, cfg_*, result,
//            cnt_clr/match_cnt with SEQDET_CNT_EN)
// ---------------------------------------------------------------------------
module seqdet_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] DEF_PAT = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    seqdet_param_if.slave bus
);
    // Fill counts accepted bits and saturates at PAT_LEN.
    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-1:0] shifted;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               ovl_q, ovl_d;
    logic               result_q, result_d;
    logic               match;

    assign shifted = {hist_q[PAT_LEN-2:0], bus.din};

    // fill_q >= PAT_LEN-1 is the same test as fill+1 >= PAT_LEN without the
    // risk of overflowing the fill width. A coincident cfg_load discards the
    // bit, so no match can be evaluated on that edge.
    assign match = bus.din_vld && !bus.cfg_load
                && (shifted == pat_q) && (fill_q >= FILL_LAST);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise a latch would be inferred.
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        ovl_d    = ovl_q;
        result_d = 1'b0;

        if (bus.cfg_load) begin
            pat_d  = bus.cfg_pat;
            ovl_d  = bus.cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.din_vld) begin
            hist_d = shifted;
            fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_ONE;
            if (match) begin
                result_d = 1'b1;
                // Non-overlapping: the next match must be built from
                // PAT_LEN fresh bits, so forget how many we have seen.
                if (!ovl_q) fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (rst) begin
            hist_q   <= '0;
            fill_q   <= '0;
            pat_q    <= DEF_PAT;
            ovl_q    <= 1'b1;
            result_q <= 1'b0;
        end else begin
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            ovl_q    <= ovl_d;
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;

`ifdef SEQDET_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter steps on the same edge that raises result, so match_cnt
    // and result change together. A clear that coincides with a match keeps
    // that match.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = match ? CNT_ONE : '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign bus.match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seqdet_param.sv
// ---------------------------------------------------------------------------
// tb_seqdet_param -- self-checking bench for seqdet_param.
//
// Two detectors share clk/rst: u_dut4 (PAT_LEN=4, DEF_PAT=1011, CNT_W=8)
// and u_dut2 (PAT_LEN=2, DEF_PAT=11, CNT_W=2). Each stimulus step pushes
// the expected result (and count, with SEQDET_CNT_EN) to a scoreboard;
// the entry is popped and compared just after the active edge.
// ---------------------------------------------------------------------------
module tb_seqdet_param;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seqdet_param_if #(.PAT_LEN(4), .CNT_W(8)) bus4 ();
    seqdet_param_if #(.PAT_LEN(2), .CNT_W(2)) bus2 ();

    seqdet_param #(.PAT_LEN(4), .DEF_PAT(4'b1011), .CNT_W(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    seqdet_param #(.PAT_LEN(2), .DEF_PAT(2'b11), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct packed {
        logic        on2;
        logic        res;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   cnt4_exp = 0;
    int   cnt2_exp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus4.din_vld  = 1'b0;
        bus4.din      = 1'b0;
        bus4.cfg_load = 1'b0;
        bus4.cfg_pat  = '0;
        bus4.cfg_ovl  = 1'b0;
        bus2.din_vld  = 1'b0;
        bus2.din      = 1'b0;
        bus2.cfg_load = 1'b0;
        bus2.cfg_pat  = '0;
        bus2.cfg_ovl  = 1'b0;
`ifdef SEQDET_CNT_EN
        bus4.cnt_clr  = 1'b0;
        bus2.cnt_clr  = 1'b0;
`endif
    endtask

    // Expected count: a clear yields 1 with a coincident match, else 0;
    // otherwise a match steps the count up to its saturation value.
    function automatic int next_cnt(input int cur, input logic clr, input logic res, input int max);
        if (clr)               return res ? 1 : 0;
        if (res && cur < max)  return cur + 1;
        return cur;
    endfunction

    task automatic step(input bit on2, input logic vld, input logic d,
                        input logic load, input logic [3:0] pat, input logic ovl,
                        input logic clr, input logic exp_res, input string tag);
        exp_t e;
        @(negedge clk);
        idle_inputs();
        if (on2) begin
            bus2.din_vld  = vld;
            bus2.din      = d;
            bus2.cfg_load = load;
            bus2.cfg_pat  = pat[1:0];
            bus2.cfg_ovl  = ovl;
`ifdef SEQDET_CNT_EN
            bus2.cnt_clr  = clr;
`endif
            cnt2_exp = next_cnt(cnt2_exp, clr, exp_res, 3);
            e = '{1'b1, exp_res, 16'(cnt2_exp)};
        end else begin
            bus4.din_vld  = vld;
            bus4.din      = d;
            bus4.cfg_load = load;
            bus4.cfg_pat  = pat;
            bus4.cfg_ovl  = ovl;
            cnt4_exp = next_cnt(cnt4_exp, 1'b0, exp_res, 255);
            e = '{1'b0, exp_res, 16'(cnt4_exp)};
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.on2) begin
            check({tag, "/res"}, 32'(bus2.result), 32'(e.res));
`ifdef SEQDET_CNT_EN
            check({tag, "/cnt"}, 32'(bus2.match_cnt), 32'(e.cnt));
`endif
        end else begin
            check({tag, "/res"}, 32'(bus4.result), 32'(e.res));
`ifdef SEQDET_CNT_EN
            check({tag, "/cnt"}, 32'(bus4.match_cnt), 32'(e.cnt));
`endif
        end
    endtask

    task automatic b4(input logic d, input logic exp_res, input string tag);
        step(1'b0, 1'b1, d, 1'b0, 4'b0000, 1'b0, 1'b0, exp_res, tag);
    endtask

    task automatic gap4(input logic d);
        step(1'b0, 1'b0, d, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, "gap");
    endtask

    task automatic load4(input logic vld, input logic d, input logic [3:0] pat,
                         input logic ovl, input string tag);
        step(1'b0, vld, d, 1'b1, pat, ovl, 1'b0, 1'b0, tag);
    endtask

    task automatic b2(input logic vld, input logic d, input logic clr,
                      input logic exp_res, input string tag);
        step(1'b1, vld, d, 1'b0, 4'b0000, 1'b0, clr, exp_res, tag);
    endtask

    // bits[n-1] is driven first; exp[i] is the result expected for bits[i].
    task automatic feed4(input int n, input logic [15:0] bits, input logic [15:0] exp,
                         input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            b4(bits[i], exp[i], $sformatf("%s[%0d]", tag, n - 1 - i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst/res4", 32'(bus4.result), 32'd0);
        check("rst/res2", 32'(bus2.result), 32'd0);
`ifdef SEQDET_CNT_EN
        check("rst/cnt4", 32'(bus4.match_cnt), 32'd0);
        check("rst/cnt2", 32'(bus2.match_cnt), 32'd0);
`endif
        rst = 1'b0;

        // Default 1011, overlapping: pulses after bits 4 and 7.
        feed4(7, 16'b1011011, 16'b0001001, "ovl");

        // Non-overlapping: only the first match of the same stream.
        load4(1'b0, 1'b0, 4'b1011, 1'b0, "cfg_novl");
        feed4(7, 16'b1011011, 16'b0001000, "novl");

        // Back to overlapping; invalid cycles (with din toggling) are ignored.
        load4(1'b0, 1'b0, 4'b1011, 1'b1, "cfg_ovl");
        b4(1'b1, 1'b0, "gap_seq[0]");
        b4(1'b0, 1'b0, "gap_seq[1]");
        gap4(1'b1);
        gap4(1'b1);
        gap4(1'b0);
        b4(1'b1, 1'b0, "gap_seq[2]");
        b4(1'b1, 1'b1, "gap_seq[3]");

        // Reset mid-sequence under a foreign pattern: default pattern and
        // overlapping mode return, the partial 101 is forgotten.
        load4(1'b0, 1'b0, 4'b0110, 1'b0, "cfg_pre_rst");
        feed4(3, 16'b101, 16'b000, "pre_rst");
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #2;
        check("midrst/res4", 32'(bus4.result), 32'd0);
`ifdef SEQDET_CNT_EN
        check("midrst/cnt4", 32'(bus4.match_cnt), 32'd0);
`endif
        cnt4_exp = 0;
        cnt2_exp = 0;
        @(negedge clk);
        rst = 1'b0;
        feed4(7, 16'b1011011, 16'b0001001, "post_rst");

        // cfg_load on the bit that would complete 1011: bit dropped, no
        // pulse, history cleared, new pattern 0110 in force.
        feed4(3, 16'b101, 16'b000, "pre_cfg");
        load4(1'b1, 1'b1, 4'b0110, 1'b1, "cfg_coinc");
        feed4(5, 16'b10110, 16'b00001, "after_cfg");

        // PAT_LEN=2, pattern 11, CNT_W=2: five overlapping matches saturate
        // the count at 3; a clear with a coincident match gives 1.
        b2(1'b1, 1'b1, 1'b0, 1'b0, "p2[0]");
        for (int i = 1; i < 6; i++) begin
            b2(1'b1, 1'b1, 1'b0, 1'b1, $sformatf("p2[%0d]", i));
        end
        b2(1'b1, 1'b1, 1'b1, 1'b1, "p2_clr_match");
        b2(1'b0, 1'b0, 1'b1, 1'b0, "p2_clr_only");
        b2(1'b1, 1'b0, 1'b0, 1'b0, "p2_zero");
        b2(1'b1, 1'b1, 1'b0, 1'b0, "p2_01");
        b2(1'b1, 1'b1, 1'b0, 1'b1, "p2_11");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
